sprite_list_loader: RTL and testbench
=====================================

# sprite_list_loader

Avalon-MM slave that sits directly upstream of the VGA LED display top. It accepts the sprite list from the CPU one 32-bit word at a time into a shadow buffer. On a software commit request, it transfers the whole list to the display as a 512-bit `gl_input` bus with a one-cycle `write` strobe. The transfer happens at the next frame start, so the display never latches a half-updated list mid-frame.

## Interface
- `NUM_SPRITES`, 20, number of sprite entries
- `ENTRY_W`, 24, bits per entry; entry layout is owned by the sprite controller and is opaque here
- `clk` input 1: single clock (50 MHz system clock)
- `reset` input 1: synchronous, active-high
- `chipselect` input 1: Avalon slave select
- `write` input 1: Avalon write strobe
- `read` input 1: Avalon read strobe
- `address` input 5: word address
- `writedata` input 32: write data
- `readdata` output 32: read data, registered
- `frame_start` input 1: one-cycle pulse, synchronous to `clk`, at start of vertical blank
- `gl_input` output 512: committed list; entry i occupies bits [24i+23:24i]; bits [511:480] are always 0
- `gl_write` output 1: one-cycle strobe; `gl_input` is valid in the same cycle
- `irq` output 1: commit-done interrupt, level

## Operation
- Register map (word addresses):
  - 0..19 is shadow entry i, R/W; bits [23:0] are used, writes ignore [31:24], reads return them as 0.
  - 20 is CTRL, W. Bit0=COMMIT requests a transfer; bit1=IRQ_ACK clears `irq`; bit2=IRQ_EN. IRQ_EN is readable at bit2; other bits read 0.
  - 21 is STATUS, R. Bit0=PENDING, bit1=IRQ. Bits [31:16] hold the frame counter.
  - 22..31: writes ignored, reads return 0.
- Accesses without `chipselect` are ignored.
- States are IDLE and PENDING.
  - IDLE to PENDING: CTRL write with COMMIT=1.
  - PENDING to IDLE: at `frame_start`. In the same cycle, copy all 20 shadow entries to `gl_input`, pulse `gl_write`, and set the irq flag.
- COMMIT while already PENDING has no effect; the request stays pending and only one transfer occurs.
- Shadow writes while PENDING are accepted and included in the pending transfer.
  - Shadow write and the `frame_start` transfer in the same cycle: the new value is NOT included. The transfer uses the pre-write shadow; the write lands in the shadow for the next commit.
- COMMIT write in the same cycle as `frame_start` while IDLE: enter PENDING and transfer at the following `frame_start`, not this one.
- The irq flag is set on each transfer and cleared by IRQ_ACK. If set and ack coincide, set wins.
- `irq` = flag & IRQ_EN.
- Frame counter: 16-bit, increments on every `frame_start` regardless of state, wraps 0xFFFF to 0.

## Timing
- Reset values: `readdata`=0, `gl_input`=0, `gl_write`=0, `irq`=0. Shadow=0, state=IDLE, IRQ_EN=0, counter=0.
- Reset mid-PENDING drops the request; no `gl_write` is issued.
- Read latency: 1 cycle. `readdata` is valid the cycle after `read`&`chipselect`, holds until the next read, and reflects state before any same-cycle write.
- Writes take effect on the clock edge where `write`&`chipselect` is high. Fixed latency, no waitrequest.
- Transfer: `gl_input` and `gl_write` are registered and update at the edge where `frame_start` is sampled high in PENDING.
  - `gl_write` is high for exactly one cycle.
  - `gl_input` holds its value until the next transfer.
- The PENDING status bit reads 1 starting from a read issued the cycle after the COMMIT write.

## Structure
- Shared package `sprite_pkg`: `NUM_SPRITES`, `ENTRY_W`, `sprite_entry_t` (logic [23:0]), register address constants (`CTRL_ADDR`=20, `STATUS_ADDR`=21), CTRL bit positions, and a `loader_state_t` enum (IDLE, PENDING).
- One sub-module, `sprite_shadow_regs`, holds the 20×24 shadow register file: write port, one read port, and a flat 480-bit snapshot output. The FSM, CTRL/STATUS, counter and output registers stay in `sprite_list_loader`.

## Test plan
- Basic commit: after reset, write entry0=0x123456 and entry19=0xABCDEF, write CTRL=0x5, pulse `frame_start`.
  - `gl_write` is high for one cycle with `gl_input[23:0]`=0x123456, `gl_input[479:456]`=0xABCDEF, `[511:480]`=0.
  - `irq`=1; a STATUS read gives 0x0001_0002.
- No commit: pulse `frame_start` three times with no COMMIT. No `gl_write`, `gl_input` stays 0, STATUS[31:16]=3.
- Same-cycle write and transfer: in PENDING, write entry0=0x000111 in the same cycle as `frame_start`.
  - The transfer carries the old entry0 value.
  - Reading address 0 afterwards returns 0x00000111.
- Double COMMIT and IRQ: write COMMIT twice, then pulse `frame_start` twice. Exactly one `gl_write`. IRQ_ACK drops `irq`; IRQ_ACK coinciding with a transfer leaves `irq`=1.
- Reset mid-PENDING: COMMIT, then assert `reset` for 1 cycle, then pulse `frame_start`. No `gl_write`; all outputs are 0 and STATUS=0.
- Address edges: write 0xFFFFFFFF to address 25 and to address 3.
  - Reading address 25 returns 0.
  - Reading address 3 returns 0x00FFFFFF one cycle after `read`.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite list loader: sizes, register map and FSM states.
package sprite_pkg;

  localparam int NUM_SPRITES = 20;
  localparam int ENTRY_W     = 24;
  localparam int SNAP_W      = NUM_SPRITES * ENTRY_W;

  typedef logic [ENTRY_W-1:0] sprite_entry_t;

  localparam logic [4:0] CTRL_ADDR   = 5'd20;
  localparam logic [4:0] STATUS_ADDR = 5'd21;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_IRQ_ACK_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT    = 2;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_IRQ_BIT     = 1;

  typedef enum logic {
    IDLE,
    PENDING
  } loader_state_t;

endpackage

// File: rtl/sprite_shadow_regs.sv
// Shadow register file for the sprite list: one write port, one read port and a
// flat snapshot of every entry so the whole list can be copied in a single cycle.
module sprite_shadow_regs
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  sprite_entry_t       wr_data,
  input  logic [4:0]          rd_addr,
  output sprite_entry_t       rd_data,
  output logic [SNAP_W-1:0]   snapshot
);

  // Flip-flops rather than RAM: every entry must be visible at once for the snapshot.
  sprite_entry_t entry_reg [NUM_SPRITES];

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg[gi] <= '0;
        end else if (wr_en && (wr_addr == 5'(gi))) begin
          entry_reg[gi] <= wr_data;
        end
      end

      assign snapshot[gi*ENTRY_W +: ENTRY_W] = entry_reg[gi];
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (rd_addr == 5'(i)) rd_data = entry_reg[i];
    end
  end

endmodule

// File: rtl/sprite_list_loader.sv
// Avalon-MM slave that buffers a sprite list from the CPU and hands it to the
// display in one 512-bit write at the first frame start after a commit.
module sprite_list_loader
  import sprite_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         chipselect,
  input  logic         write,
  input  logic         read,
  input  logic [4:0]   address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  input  logic         frame_start,
  output logic [511:0] gl_input,
  output logic         gl_write,
  output logic         irq
);

  loader_state_t state_reg, state_next;
  logic [511:0]  gl_input_reg;
  logic          gl_write_reg;
  logic [31:0]   readdata_reg;
  logic [31:0]   read_word;
  logic          irq_flag_reg;
  logic          irq_en_reg;
  logic [15:0]   frame_cnt_reg;

  logic          wr_en, rd_en, shadow_wr, ctrl_wr, commit_req, irq_ack, transfer;
  sprite_entry_t shadow_rd_data;
  logic [SNAP_W-1:0] shadow_snapshot;
  logic          unused_writedata;

  assign wr_en      = chipselect & write;
  assign rd_en      = chipselect & read;
  assign shadow_wr  = wr_en && (address < 5'(NUM_SPRITES));
  assign ctrl_wr    = wr_en && (address == CTRL_ADDR);
  assign commit_req = ctrl_wr & writedata[CTRL_COMMIT_BIT];
  assign irq_ack    = ctrl_wr & writedata[CTRL_IRQ_ACK_BIT];
  assign transfer   = (state_reg == PENDING) & frame_start;
  assign unused_writedata = ^writedata[31:24];

  sprite_shadow_regs u_shadow (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (shadow_wr),
    .wr_addr  (address),
    .wr_data  (writedata[ENTRY_W-1:0]),
    .rd_addr  (address),
    .rd_data  (shadow_rd_data),
    .snapshot (shadow_snapshot)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (commit_req)  state_next = PENDING;
      PENDING: if (frame_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    read_word = '0;
    if (address < 5'(NUM_SPRITES)) begin
      read_word = {8'h00, shadow_rd_data};
    end else if (address == CTRL_ADDR) begin
      read_word[CTRL_IRQ_EN_BIT] = irq_en_reg;
    end else if (address == STATUS_ADDR) begin
      read_word[31:16]              = frame_cnt_reg;
      read_word[STATUS_IRQ_BIT]     = irq_flag_reg;
      read_word[STATUS_PENDING_BIT] = (state_reg == PENDING);
    end
  end

  // The snapshot is taken from the registered shadow, so a same-cycle shadow
  // write lands after the copy and belongs to the next commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      gl_input_reg  <= '0;
      gl_write_reg  <= 1'b0;
      readdata_reg  <= '0;
      irq_flag_reg  <= 1'b0;
      irq_en_reg    <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gl_write_reg <= transfer;
      if (transfer) gl_input_reg <= {32'h0, shadow_snapshot};
      if (transfer) irq_flag_reg <= 1'b1;
      else if (irq_ack) irq_flag_reg <= 1'b0;
      if (ctrl_wr) irq_en_reg <= writedata[CTRL_IRQ_EN_BIT];
      if (frame_start) frame_cnt_reg <= frame_cnt_reg + 16'd1;
      if (rd_en) readdata_reg <= read_word;
    end
  end

  assign gl_input = gl_input_reg;
  assign gl_write = gl_write_reg;
  assign readdata = readdata_reg;
  assign irq      = irq_flag_reg & irq_en_reg;

endmodule

// File: tb/tb_sprite_list_loader.sv
// Directed self-checking bench for sprite_list_loader.
module tb_sprite_list_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         chipselect;
  logic         write;
  logic         read;
  logic [4:0]   address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         frame_start;
  logic [511:0] gl_input;
  logic         gl_write;
  logic         irq;

  int n_compared   = 0;
  int n_mismatched = 0;
  int gl_write_seen = 0;

  sprite_list_loader dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .frame_start (frame_start),
    .gl_input    (gl_input),
    .gl_write    (gl_write),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (gl_write) gl_write_seen++;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // One frame_start cycle, optionally with a bus write in the same cycle;
  // returns outputs sampled just after the edge.
  task automatic frame_pulse(input logic with_wr, input logic [4:0] a, input logic [31:0] d,
                             output logic gw, output logic [511:0] gi, output logic ir);
    @(negedge clk);
    frame_start = 1'b1;
    chipselect = with_wr; write = with_wr; address = a; writedata = d;
    @(posedge clk); #1;
    frame_start = 1'b0; chipselect = 1'b0; write = 1'b0;
    gw = gl_write; gi = gl_input; ir = irq;
  endtask

  initial begin
    logic [31:0]  rd;
    logic         gw, ir;
    logic [511:0] gi;
    int           base;

    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = '0; writedata = '0; frame_start = 1'b0;

    // Reset state
    do_reset();
    check_val("reset_readdata", 512'(readdata), 512'h0);
    check_val("reset_gl_input", gl_input, 512'h0);
    check_val("reset_gl_write", 512'(gl_write), 512'h0);
    check_val("reset_irq", 512'(irq), 512'h0);

    // Basic commit
    bus_write(5'd0, 32'hFF12_3456);
    bus_write(5'd19, 32'h00AB_CDEF);
    bus_write(5'd20, 32'h0000_0005);
    bus_read(5'd21, rd);
    check_val("pending_status", 512'(rd), 512'h0000_0001);
    base = gl_write_seen;
    frame_pulse(1'b0, 5'd0, 32'h0, gw, gi, ir);
    check_val("basic_gl_write", 512'(gw), 512'h1);
    check_val("basic_entry0", 512'(gi[23:0]), 512'h12_3456);
    check_val("basic_entry19", 512'(gi[479:456]), 512'hAB_CDEF);
    check_val("basic_top_bits", 512'(gi[511:480]), 512'h0);
    check_val("basic_irq", 512'(ir), 512'h1);
    bus_read(5'd21, rd);
    check_val("basic_status", 512'(rd), 512'h0001_0002);
    check_val("basic_one_strobe", 512'(gl_write_seen - base), 512'h1);
    bus_read(5'd20, rd);
    check_val("ctrl_readback", 512'(rd), 512'h4);

    // No commit: three frames, nothing transferred
    do_reset();
    base = gl_write_seen;
    for (int i = 0; i < 3; i++) frame_pulse(1'b0, 5'd0, 32'h0, gw, gi, ir);
    check_val("nocommit_strobes", 512'(gl_write_seen - base), 512'h0);
    check_val("nocommit_gl_input", gl_input, 512'h0);
    bus_read(5'd21, rd);
    check_val("nocommit_counter", 512'(rd[31:16]), 512'h3);

    // Same-cycle shadow write and transfer
    bus_write(5'd0, 32'h00AA_AAAA);
    bus_write(5'd20, 32'h0000_0005);
    frame_pulse(1'b1, 5'd0, 32'h0000_0111, gw, gi, ir);
    check_val("samecyc_gl_write", 512'(gw), 512'h1);
    check_val("samecyc_old_entry0", 512'(gi[23:0]), 512'hAA_AAAA);
    bus_read(5'd0, rd);
    check_val("samecyc_shadow0", 512'(rd), 512'h0000_0111);

    // Double commit, IRQ ack, ack coinciding with transfer
    bus_write(5'd20, 32'h0000_0006);
    check_val("ack_clears_irq", 512'(irq), 512'h0);
    base = gl_write_seen;
    bus_write(5'd20, 32'h0000_0005);
    bus_write(5'd20, 32'h0000_0005);
    frame_pulse(1'b0, 5'd0, 32'h0, gw, gi, ir);
    frame_pulse(1'b0, 5'd0, 32'h0, gw, gi, ir);
    check_val("double_commit_strobes", 512'(gl_write_seen - base), 512'h1);
    check_val("double_commit_irq", 512'(irq), 512'h1);
    bus_write(5'd20, 32'h0000_0006);
    check_val("ack_drops_irq", 512'(irq), 512'h0);
    bus_write(5'd20, 32'h0000_0005);
    frame_pulse(1'b1, 5'd20, 32'h0000_0006, gw, gi, ir);
    check_val("ack_vs_set_strobe", 512'(gw), 512'h1);
    check_val("ack_vs_set_irq", 512'(ir), 512'h1);

    // COMMIT coinciding with frame_start while idle defers to the next frame
    frame_pulse(1'b1, 5'd20, 32'h0000_0005, gw, gi, ir);
    check_val("commit_at_frame_no_xfer", 512'(gw), 512'h0);
    frame_pulse(1'b0, 5'd0, 32'h0, gw, gi, ir);
    check_val("commit_at_frame_next_xfer", 512'(gw), 512'h1);

    // Reset mid-PENDING drops the request
    bus_write(5'd20, 32'h0000_0005);
    do_reset();
    bus_read(5'd21, rd);
    check_val("rst_pending_status", 512'(rd), 512'h0);
    base = gl_write_seen;
    frame_pulse(1'b0, 5'd0, 32'h0, gw, gi, ir);
    check_val("rst_pending_strobes", 512'(gl_write_seen - base), 512'h0);
    check_val("rst_pending_gl_input", gi, 512'h0);
    check_val("rst_pending_irq", 512'(ir), 512'h0);
    bus_read(5'd21, rd);
    check_val("rst_pending_status_after", 512'(rd), 512'h0001_0000);

    // Address edges
    bus_write(5'd25, 32'hFFFF_FFFF);
    bus_write(5'd3, 32'hFFFF_FFFF);
    bus_read(5'd25, rd);
    check_val("addr25_read", 512'(rd), 512'h0);
    bus_read(5'd3, rd);
    check_val("addr3_read", 512'(rd), 512'h00FF_FFFF);
    @(negedge clk);
    check_val("readdata_holds", 512'(readdata), 512'h00FF_FFFF);

    // Accesses without chipselect are ignored
    @(negedge clk);
    write = 1'b1; address = 5'd3; writedata = 32'h0;
    @(posedge clk); #1;
    write = 1'b0;
    bus_read(5'd3, rd);
    check_val("no_cs_write_ignored", 512'(rd), 512'h00FF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
